quad7seg_arbiter: RTL and testbench
===================================

# quad7seg_arbiter

Shares the four-digit seven-segment display driver between two independent requesters, A and B. It is a round-robin arbiter with a guaranteed minimum dwell time, so the display cannot flicker between sources. It sits directly upstream of the quad seven-segment driver and feeds that driver's per-digit value and dot inputs from the current owner. When neither requester holds the display, it drives a blank indication.

## Interface
- DWELL, 50_000_000: minimum number of cycles an owner keeps the display (with its req held) before the other requester can take it; legal range ≥1.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_a  in  1  requester A wants the display (level)
- data_a  in  16  A's four hex digits; [3:0]=digit 0 … [15:12]=digit 3
- dots_a  in  4  A's decimal points; bit i = digit i
- req_b  in  1  requester B wants the display (level)
- data_b  in  16  B's digits, same packing
- dots_b  in  4  B's decimal points
- gnt_a  out  1  A owns the display (registered level)
- gnt_b  out  1  B owns the display (registered level)
- val0, val1, val2, val3  out  4 each  digit values to the display driver
- dot0, dot1, dot2, dot3  out  1 each  decimal points to the display driver
- blank  out  1  no owner; the display driver must blank all digits

## Operation
- The state machine has three states: IDLE, SHOW_A, SHOW_B.
  - gnt_a=1 iff SHOW_A; gnt_b=1 iff SHOW_B; blank=1 iff IDLE.
  - Never both grants high.
- last_owner register (A/B) drives the round-robin tie break.
- Dwell counter cnt:
  - width $clog2(DWELL+1).
  - Set to 1 on the edge that grants; increments each edge while the same owner is retained; saturates at DWELL.
- From IDLE:
  - only req_a → SHOW_A.
  - only req_b → SHOW_B.
  - both → the side that is not last_owner.
  - none → stay in IDLE.
- In SHOW_A (SHOW_B is symmetric):
  - req_a=0 → if req_b=1, go directly to SHOW_B (no idle gap), else go to IDLE. Either way last_owner<=A. Dropping req ignores dwell.
  - req_a=1, req_b=1, cnt==DWELL → SHOW_B, last_owner<=A.
  - otherwise stay. With no competitor the owner keeps the display indefinitely.
- Display registers:
  - On every edge whose next state is SHOW_x, val0..3/dot0..3 load data_x/dots_x. Updates are live while owned.
  - Mapping: val_i<=data_x[4i+3:4i], dot_i<=dots_x[i].
  - On entering or staying in IDLE, the values hold their last contents; only blank rises.
- Reset values (next edge with rst=1, regardless of state):
  - state=IDLE, gnt_a=0, gnt_b=0, blank=1.
  - val0..3=4'h0, dot0..3=0, cnt=0.
  - last_owner=B, so A wins the first tie.
- rst overrides all other inputs on that edge, including mid-dwell. Arbitration restarts from IDLE on the first edge after rst falls.

## Timing
- Grant latency is one cycle. A req sampled high at edge k asserts gnt, loads val/dot, and drops blank, all at edge k.
- Data latency is one cycle: a data_x change is visible on val_i at the next edge while x owns the display.
- Minimum ownership: an owner that holds its req sees gnt high for at least DWELL consecutive cycles. Handover occurs at the first edge with cnt==DWELL and a competing req.
- Release: an owner's req sampled low at edge k drops its gnt at edge k. The competing grant, if any, rises at the same edge k.
- Requesters must keep req high until they see gnt before expecting service. A req pulse that is never seen while the block is in an eligible state is lost.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset: hold rst 2 cycles with req_a=req_b=1 → gnt_a=gnt_b=0, blank=1, all val=0 and dot=0. On the first edge after release, gnt_a=1 (tie goes to A).
- Single owner: DWELL=4; req_a=1, data_a=16'h0123, dots_a=4'b1010 → one cycle later gnt_a=1, blank=0, val3..0=0,1,2,3, dot3..0=1,0,1,0. Changing data_a to 16'h4567 → val updates next cycle.
- Dwell preemption: DWELL=4; A granted; req_b rises in A's first granted cycle → gnt_a high exactly 4 cycles, then gnt_b=1 the same edge gnt_a=0, and val follows data_b.
- Early release: A granted at cnt=2, req_a drops with req_b=0 → next edge gnt_a=0, blank=1, val retains A's last digits. req_b then rises → gnt_b next cycle.
- Round robin: req_a and req_b both held continuously, DWELL=3 → grants alternate A,B,A,B every 3 cycles with no idle cycle between them.
- Reset mid-dwell: rst=1 while B owns at cnt=1 → next edge IDLE, blank=1. After release with both requesting, A is granted.

Source files
------------

// File: rtl/quad7seg_arbiter.sv
// Round-robin owner selection for the shared four-digit seven-segment driver.
// A minimum dwell applies before a competing requester may take the display.
module quad7seg_arbiter #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  dots_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  dots_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  val0,
  output logic [3:0]  val1,
  output logic [3:0]  val2,
  output logic [3:0]  val3,
  output logic        dot0,
  output logic        dot1,
  output logic        dot2,
  output logic        dot3,
  output logic        blank
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;  // 1 when B was the most recent owner
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    dots_q, dots_d;
  logic          dwell_done;

  assign dwell_done = (cnt_q == CW'(DWELL));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      data_q   <= '0;
      dots_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dots_q   <= dots_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? SHOW_A : SHOW_B;
        end else if (req_a) begin
          state_d = SHOW_A;
        end else if (req_b) begin
          state_d = SHOW_B;
        end
      end
      SHOW_A: begin
        // Releasing ignores dwell; the competitor takes over with no idle gap.
        if (!req_a) begin
          state_d  = req_b ? SHOW_B : IDLE;
          last_b_d = 1'b0;
        end else if (req_b && dwell_done) begin
          state_d  = SHOW_B;
          last_b_d = 1'b0;
        end
      end
      SHOW_B: begin
        if (!req_b) begin
          state_d  = req_a ? SHOW_A : IDLE;
          last_b_d = 1'b1;
        end else if (req_a && dwell_done) begin
          state_d  = SHOW_A;
          last_b_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    dots_d = dots_q;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_d != state_q) begin
      cnt_d = CW'(1);
    end else if (!dwell_done) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Digits track the owner live; in IDLE they hold their last contents.
    if (state_d == SHOW_A) begin
      data_d = data_a;
      dots_d = dots_a;
    end else if (state_d == SHOW_B) begin
      data_d = data_b;
      dots_d = dots_b;
    end
  end

  always_comb begin
    gnt_a = (state_q == SHOW_A);
    gnt_b = (state_q == SHOW_B);
    blank = (state_q == IDLE);
    val0  = data_q[3:0];
    val1  = data_q[7:4];
    val2  = data_q[11:8];
    val3  = data_q[15:12];
    dot0  = dots_q[0];
    dot1  = dots_q[1];
    dot2  = dots_q[2];
    dot3  = dots_q[3];
  end

endmodule

// File: tb/tb_quad7seg_arbiter.sv
// Directed scenarios plus randomized requests, checked every cycle against an
// ownership model that tracks who holds the display and for how many cycles.
module tb_quad7seg_arbiter;

  localparam int unsigned DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [3:0]  dots_a = '0, dots_b = '0;
  logic        gnt_a, gnt_b, blank;
  logic [3:0]  val0, val1, val2, val3;
  logic        dot0, dot1, dot2, dot3;

  int checks = 0;
  int errors = 0;

  quad7seg_arbiter #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a), .dots_a(dots_a),
    .req_b(req_b), .data_b(data_b), .dots_b(dots_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .dot0(dot0), .dot1(dot1), .dot2(dot2), .dot3(dot3),
    .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] vals();
    return {val3, val2, val1, val0};
  endfunction

  function automatic logic [3:0] dots();
    return {dot3, dot2, dot1, dot0};
  endfunction

  // Model: owner 0=none 1=A 2=B, held = cycles the current owner has had gnt.
  bit          m_valid = 1'b0;
  int          m_owner, m_last, m_held, m_nxt;
  logic [15:0] m_data;
  logic [3:0]  m_dots;
  bit          m_want[3];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_owner = 0;
      m_last  = 2;
      m_held  = 0;
      m_data  = '0;
      m_dots  = '0;
    end else if (m_valid) begin
      m_want[0] = 1'b0;
      m_want[1] = req_a;
      m_want[2] = req_b;
      if (m_owner == 0) begin
        if (m_want[1] && m_want[2]) m_nxt = 3 - m_last;
        else if (m_want[1])         m_nxt = 1;
        else if (m_want[2])         m_nxt = 2;
        else                        m_nxt = 0;
      end else if (!m_want[m_owner]) begin
        m_nxt  = m_want[3 - m_owner] ? 3 - m_owner : 0;
        m_last = m_owner;
      end else if (m_want[3 - m_owner] && m_held >= DWELL) begin
        m_nxt  = 3 - m_owner;
        m_last = m_owner;
      end else begin
        m_nxt = m_owner;
      end
      if (m_nxt == 0)            m_held = 0;
      else if (m_nxt != m_owner) m_held = 1;
      else                       m_held++;
      m_owner = m_nxt;
      if (m_owner == 1) begin
        m_data = data_a;
        m_dots = dots_a;
      end else if (m_owner == 2) begin
        m_data = data_b;
        m_dots = dots_b;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_gnt_a", 32'(gnt_a), 32'(m_owner == 1));
      chk("cyc_gnt_b", 32'(gnt_b), 32'(m_owner == 2));
      chk("cyc_blank", 32'(blank), 32'(m_owner == 0));
      chk("cyc_vals", 32'(vals()), 32'(m_data));
      chk("cyc_dots", 32'(dots()), 32'(m_dots));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    // Reset held two cycles with both requesting
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1;
    data_a = 16'h9999; data_b = 16'h7777; dots_a = 4'hf; dots_b = 4'hf;
    tick(); tick();
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_vals", 32'(vals()), 32'h0);
    chk("rst_dots", 32'(dots()), 32'h0);
    rst = 1'b0;
    tick();
    chk("tie_gnt_a", 32'(gnt_a), 32'd1);
    chk("tie_gnt_b", 32'(gnt_b), 32'd0);
    $display("txn reset_tie gnt_a=%0b gnt_b=%0b", gnt_a, gnt_b);

    // Single owner with live data update
    do_reset();
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h0123; dots_a = 4'b1010;
    tick();
    chk("single_gnt_a", 32'(gnt_a), 32'd1);
    chk("single_blank", 32'(blank), 32'd0);
    chk("single_vals", 32'(vals()), 32'h0123);
    chk("single_dots", 32'(dots()), 32'b1010);
    data_a = 16'h4567;
    tick();
    chk("single_update", 32'(vals()), 32'h4567);
    $display("txn single_owner vals=%h dots=%b", vals(), dots());

    // Preemption after exactly DWELL cycles
    do_reset();
    req_a = 1'b1; req_b = 1'b0;
    tick();
    req_b = 1'b1; data_b = 16'h89ab; dots_b = 4'b0110;
    n = 1;
    tick();
    while (gnt_a && n < 20) begin
      n++;
      tick();
    end
    chk("dwell_len", 32'(n), 32'd4);
    chk("dwell_gnt_b", 32'(gnt_b), 32'd1);
    chk("dwell_vals", 32'(vals()), 32'h89ab);
    $display("txn dwell_preempt a_cycles=%0d gnt_b=%0b", n, gnt_b);

    // Early release, display holds A's digits, then B served
    do_reset();
    req_a = 1'b1; req_b = 1'b0; data_a = 16'hcafe; dots_a = 4'b0011;
    tick(); tick();
    req_a = 1'b0; data_a = 16'h1111;
    tick();
    chk("rel_gnt_a", 32'(gnt_a), 32'd0);
    chk("rel_blank", 32'(blank), 32'd1);
    chk("rel_vals", 32'(vals()), 32'hcafe);
    chk("rel_dots", 32'(dots()), 32'b0011);
    req_b = 1'b1; data_b = 16'hbeef;
    tick();
    chk("rel_gnt_b", 32'(gnt_b), 32'd1);
    chk("rel_vals_b", 32'(vals()), 32'hbeef);
    $display("txn early_release vals=%h gnt_b=%0b", vals(), gnt_b);

    // Round robin with both held: A,B alternating every DWELL cycles
    do_reset();
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 4 * DWELL; i++) begin
      tick();
      chk("rr_gnt_a", 32'(gnt_a), 32'(((i / DWELL) % 2) == 0));
      chk("rr_gnt_b", 32'(gnt_b), 32'(((i / DWELL) % 2) == 1));
    end
    $display("txn round_robin cycles=%0d", 4 * DWELL);

    // Reset while B owns mid-dwell
    do_reset();
    req_a = 1'b0; req_b = 1'b1;
    tick();
    chk("mid_gnt_b", 32'(gnt_b), 32'd1);
    rst = 1'b1; req_a = 1'b1;
    tick();
    chk("mid_rst_gnt_b", 32'(gnt_b), 32'd0);
    chk("mid_rst_blank", 32'(blank), 32'd1);
    rst = 1'b0;
    tick();
    chk("mid_after_gnt_a", 32'(gnt_a), 32'd1);
    $display("txn reset_mid_dwell gnt_a=%0b", gnt_a);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst    = ($urandom_range(0, 127) == 0);
      req_a  = ($urandom_range(0, 4) == 0) ? ~req_a : req_a;
      req_b  = ($urandom_range(0, 4) == 0) ? ~req_b : req_b;
      data_a = 16'($urandom);
      data_b = 16'($urandom);
      dots_a = 4'($urandom);
      dots_b = 4'($urandom);
      tick();
    end
    $display("txn random cycles=2000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_grants actual=11 required=not both at %0t", $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
